// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-window measurement blocks.
package pulse_pkg;

    typedef enum logic [1:0] {
        PW_IDLE   = 2'd0,
        PW_COUNT  = 2'd1,
        PW_REPORT = 2'd2
    } pw_state_e;

    localparam int PW_WINDOW_W = 16;
    localparam int PW_CNT_W    = 16;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for a single-bit pulse train; rise_o is combinational
// against the previous-cycle sample.
module pulse_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic rise_o
);

    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_i;
        end
    end

    assign rise_o = pulse_i & ~pulse_q;

endmodule

// File: rtl/pulse_window_counter.sv
// Counts rising edges of pulse_i over an N-cycle gate window and hands the
// saturating count downstream on a valid/ready output.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PW_IDLE   | waiting for start_i; last result still visible on count_o
// PW_COUNT  | gate open, counting edges while the down-counter runs out
// PW_REPORT | result held with count_valid_o until count_ready_i
module pulse_window_counter
    import pulse_pkg::*;
#(
    parameter int WINDOW_W = PW_WINDOW_W,
    parameter int CNT_W    = PW_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pulse_i,
    input  logic                start_i,
    input  logic [WINDOW_W-1:0] window_len_i,
    output logic                busy_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                count_valid_o,
    input  logic                count_ready_i,
    output logic                overflow_o
);

    pw_state_e           state;
    logic [WINDOW_W-1:0] win_cnt;
    logic                rise;

    pulse_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .pulse_i (pulse_i),
        .rise_o  (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PW_IDLE;
            win_cnt       <= '0;
            count_o       <= '0;
            count_valid_o <= 1'b0;
            overflow_o    <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            case (state)
                PW_IDLE: begin
                    if (start_i) begin
                        count_o    <= '0;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b1;
                        if (window_len_i == '0) begin
                            state         <= PW_REPORT;
                            count_valid_o <= 1'b1;
                        end else begin
                            win_cnt <= window_len_i;
                            state   <= PW_COUNT;
                        end
                    end
                end
                PW_COUNT: begin
                    if (rise) begin
                        if (&count_o) begin
                            overflow_o <= 1'b1;
                        end else begin
                            count_o <= count_o + CNT_W'(1);
                        end
                    end
                    win_cnt <= win_cnt - WINDOW_W'(1);
                    // The edge sampled on the terminal cycle is still counted above.
                    if (win_cnt == WINDOW_W'(1)) begin
                        state         <= PW_REPORT;
                        count_valid_o <= 1'b1;
                    end
                end
                PW_REPORT: begin
                    if (count_ready_i) begin
                        state         <= PW_IDLE;
                        count_valid_o <= 1'b0;
                        busy_o        <= 1'b0;
                    end
                end
                default: begin
                    state         <= PW_IDLE;
                    count_valid_o <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pulse_window_counter.md
Name: pulse_window_counter

Overview:
Consumer stage for the single-bit pulse train produced by pulse_generator. It counts rising edges of that train over a programmable gate window of N clock cycles, then presents the count on a valid/ready output. Downstream status or register logic reads the result, giving a measurement of pulse rate per window.

Parameters:
WINDOW_W, 16, width of the window-length input and of the internal cycle down-counter
CNT_W, 16, width of the edge count result; the count saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
pulse_i  input  1  pulse train from upstream pulse_generator (PULSE_O)
start_i  input  1  single-cycle request to open a window; sampled only in IDLE
window_len_i  input  WINDOW_W  window length N in cycles; latched when start_i is accepted
busy_o  input-side status, output  1  high in COUNT and REPORT states
count_o  output  CNT_W  rising-edge count for the last window
count_valid_o  output  1  result valid; held until accepted
count_ready_i  input  1  downstream accept
overflow_o  output  1  count saturated during the last window; qualified by count_valid_o

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, pulse_q=0, window counter=0, count_o=0, count_valid_o=0, overflow_o=0, busy_o=0.
- Edge detect:
  - pulse_q <= pulse_i on every cycle, in all states.
  - In a given cycle, edge = pulse_i & ~pulse_q.
  - An input already high when the window opens is not counted unless it falls and rises again inside the window.
- State machine: 2-bit states IDLE, COUNT, REPORT.
- IDLE:
  - If start_i=1 at edge T, latch N=window_len_i, clear count_o and overflow_o.
  - If N=0, go to REPORT. Otherwise load the down-counter with N and go to COUNT.
  - start_i is ignored in every other state; it is neither queued nor remembered.
- COUNT:
  - Occupies exactly N cycles, T+1..T+N.
  - Each cycle: if edge=1 then count_o <= count_o+1. If count_o already equals all-ones, count_o holds and overflow_o <= 1.
  - The down-counter decrements each cycle. When it reaches 1 in COUNT, the next state is REPORT; that final cycle's edge is still counted.
- REPORT:
  - count_valid_o=1, registered and asserted from cycle T+N+1 (T+1 when N=0).
  - count_o and overflow_o are stable while count_valid_o=1.
  - Transfer happens when count_valid_o & count_ready_i. On the next cycle the state is IDLE and count_valid_o=0.
  - count_o and overflow_o retain their values after transfer until the next accepted start_i.
  - count_ready_i is a don't-care outside REPORT.
- busy_o = (state != IDLE), registered.
- Reset mid-operation: rst in any state returns the block to the reset values on the next edge. A partial window is discarded and no result is emitted.
- Unreachable state encoding: the next state is IDLE.

Decomposition:
- Shared package pulse_pkg:
  - state encoding constants PW_IDLE=2'd0, PW_COUNT=2'd1, PW_REPORT=2'd2;
  - default widths PW_WINDOW_W=16 and PW_CNT_W=16.
- One natural sub-module: pulse_edge_detect (clk, rst, pulse_i -> rise_o). It holds the pulse_q register and the combinational rise output, and is reusable by other pulse consumers.

Test Plan:
- Alternating pulse_i 0,1,0,1… (upstream pulse_generator output), start_i with N=8 -> count_valid_o at T+9, count_o=4, overflow_o=0, busy_o high T+1..T+9.
- pulse_i held at 1 from before start, N=10 -> count_o=0. Then pulse_i drops for 1 cycle mid-window and rises again -> count_o=1.
- N=0 with pulse_i toggling -> count_valid_o=1 at T+1, count_o=0, no COUNT cycles.
- CNT_W=3, alternating input, N=20 -> count_o=7 (saturated), overflow_o=1.
- count_ready_i low for 5 cycles in REPORT while start_i pulses and pulse_i toggles -> count_valid_o and count_o unchanged, start_i ignored. On ready=1, one transfer, then IDLE, and the next start_i is accepted.
- rst asserted at window cycle 3 of N=8 -> next cycle state IDLE, count_o=0, count_valid_o=0, busy_o=0, and no result ever appears for that window.
